// File: rtl/fifo_pkg.sv
// Shared FIFO package.
// Holds the read-mode constants selecting first-word-fall-through or
// registered read, and a helper giving the occupancy counter width for a
// given depth (one extra bit so that a count equal to the depth fits).
package fifo_pkg;

    localparam int unsigned FIFO_MODE_FWFT = 1;
    localparam int unsigned FIFO_MODE_REG  = 0;

    function automatic int unsigned occ_width(input int unsigned depth);
        return int'($clog2(depth)) + 1;
    endfunction

endpackage

// File: rtl/fifo_wm_if.sv
// Stream interface between a producer/consumer and fifo_wm.
// Signals:
//   push_i / dat_i         write request and write data
//   full_o                 FIFO cannot accept a write
//   pop_i / dat_o          read request and read data
//   empty_o                FIFO holds no data
//   cnt_o                  current occupancy
// Modports: master = producer/consumer side, slave = FIFO side.
interface fifo_wm_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = occ_width(8)
);

    logic                  push_i;
    logic [DATA_WIDTH-1:0] dat_i;
    logic                  full_o;
    logic                  pop_i;
    logic [DATA_WIDTH-1:0] dat_o;
    logic                  empty_o;
    logic [CNT_WIDTH-1:0]  cnt_o;

    modport master (
        output push_i, dat_i, pop_i,
        input  full_o, dat_o, empty_o, cnt_o
    );

    modport slave (
        input  push_i, dat_i, pop_i,
        output full_o, dat_o, empty_o, cnt_o
    );

endinterface

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer for FIFOs of arbitrary (non-power-of-two) depth.
// Ports:
//   clk_i    clock
//   rst_n_i  asynchronous active-low reset, pointer resets to 0
//   clr_i    synchronous clear to 0, has priority over inc_i
//   inc_i    advance by one, wrapping from DEPTH-1 to 0
//   ptr_o    current pointer value
module fifo_wrap_ptr #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 clr_i,
    input  logic                 inc_i,
    output logic [PTR_WIDTH-1:0] ptr_o
);

    localparam logic [PTR_WIDTH-1:0] LastIdx = PTR_WIDTH'(DEPTH - 1);

    logic [PTR_WIDTH-1:0] ptr_q, ptr_d;

    // Explicit wrap at DEPTH-1: natural overflow is only correct for powers of two.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == LastIdx) ? '0 : ptr_q + PTR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_wm.sv
// Single-clock FIFO with arbitrary depth, FWFT or registered read,
// programmable almost-full/almost-empty watermarks and optional sticky
// overflow/underflow flags.
// Ports:
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   flush_i              synchronous clear of pointers and count
//   bus                  fifo_wm_if slave: push/dat_i/full, pop/dat_o/empty, cnt
//   afull_thr_i          afull_o = cnt >= afull_thr_i
//   aempty_thr_i         aempty_o = cnt <= aempty_thr_i
//   clr_err_i            clears sticky error flags
//   overflow_o           sticky: push attempted while full
//   underflow_o          sticky: pop attempted while empty
// Build option: define FIFO_WM_ERR_EN to implement the sticky error flags;
// otherwise overflow_o/underflow_o are tied low and clr_err_i is ignored.
module fifo_wm
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned BUFFER_DEPTH     = 8,
    parameter int unsigned LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH),
    parameter int unsigned FWFT             = FIFO_MODE_FWFT
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    flush_i,
    fifo_wm_if.slave                bus,
    input  logic [LOG_BUFFER_DEPTH:0] afull_thr_i,
    input  logic [LOG_BUFFER_DEPTH:0] aempty_thr_i,
    output logic                    afull_o,
    output logic                    aempty_o,
    input  logic                    clr_err_i,
    output logic                    overflow_o,
    output logic                    underflow_o
);

    localparam int unsigned CntW = LOG_BUFFER_DEPTH + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(BUFFER_DEPTH);

    logic [CntW-1:0]             cnt_q, cnt_d;
    logic [LOG_BUFFER_DEPTH-1:0] wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0]       mem_q [BUFFER_DEPTH];

    logic full, empty;
    logic push_hdshk, pop_hdshk;
    logic wr_en, rd_en;

    assign full  = (cnt_q == DepthCnt);
    assign empty = (cnt_q == '0);

    // Full+push+pop accepts only the pop; empty+push+pop accepts only the push.
    assign push_hdshk = bus.push_i & ~full;
    assign pop_hdshk  = bus.pop_i & ~empty;

    // Flush overrides both handshakes.
    assign wr_en = push_hdshk & ~flush_i;
    assign rd_en = pop_hdshk & ~flush_i;

    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (push_hdshk && !pop_hdshk) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (pop_hdshk && !push_hdshk) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    fifo_wrap_ptr #(
        .DEPTH     (BUFFER_DEPTH),
        .PTR_WIDTH (LOG_BUFFER_DEPTH)
    ) u_wr_ptr (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (flush_i),
        .inc_i   (wr_en),
        .ptr_o   (wr_ptr)
    );

    fifo_wrap_ptr #(
        .DEPTH     (BUFFER_DEPTH),
        .PTR_WIDTH (LOG_BUFFER_DEPTH)
    ) u_rd_ptr (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (flush_i),
        .inc_i   (rd_en),
        .ptr_o   (rd_ptr)
    );

    // Storage resets to zero so that FWFT read data is defined after reset;
    // flush leaves contents in place.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(BUFFER_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr] <= bus.dat_i;
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign bus.dat_o = mem_q[rd_ptr];
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] dat_q;

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                dat_q <= '0;
            end else if (rd_en) begin
                dat_q <= mem_q[rd_ptr];
            end
        end

        assign bus.dat_o = dat_q;
    end

    assign bus.full_o  = full;
    assign bus.empty_o = empty;
    assign bus.cnt_o   = cnt_q;

    // A threshold above the depth can never be reached, so afull_o stays low.
    assign afull_o  = (cnt_q >= afull_thr_i);
    assign aempty_o = (cnt_q <= aempty_thr_i);

`ifdef FIFO_WM_ERR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // Clear first so that a new error in the clearing cycle still sets.
    always_comb begin
        ovf_d = clr_err_i ? 1'b0 : ovf_q;
        unf_d = clr_err_i ? 1'b0 : unf_q;
        if (bus.push_i && full && !flush_i) begin
            ovf_d = 1'b1;
        end
        if (bus.pop_i && empty && !flush_i) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err_i;
    assign overflow_o     = 1'b0;
    assign underflow_o    = 1'b0;
`endif

endmodule

// File: doc/fifo_wm.md
# fifo_wm

Synchronous single-clock FIFO, next generation of the common buffer. It adds arbitrary (non-power-of-two) depth, a selectable first-word-fall-through or registered-read mode, programmable almost-full/almost-empty watermarks, and optional sticky overflow/underflow error flags. It sits between stream producers and consumers in peripherals (UART/SPI/DMA paths) where software-programmed thresholds drive interrupts or flow control.

## Interface
- DATA_WIDTH, 32: entry width in bits.
- BUFFER_DEPTH, 8: number of entries; any value >= 2, power of two not required.
- LOG_BUFFER_DEPTH, $clog2(BUFFER_DEPTH): pointer width.
- FWFT, 1: 1 = first-word-fall-through; 0 = registered read.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_n_i  in  1  reset; asynchronous and active-low.
- flush_i  in  1  synchronous clear of pointers and count.
- push_i  in  1  write request.
- dat_i  in  DATA_WIDTH  write data.
- full_o  out  1  cnt_o == BUFFER_DEPTH.
- pop_i  in  1  read request.
- dat_o  out  DATA_WIDTH  read data (mode-dependent, see Operation).
- empty_o  out  1  cnt_o == 0.
- cnt_o  out  LOG_BUFFER_DEPTH+1  current occupancy.
- afull_thr_i  in  LOG_BUFFER_DEPTH+1  almost-full threshold.
- aempty_thr_i  in  LOG_BUFFER_DEPTH+1  almost-empty threshold.
- afull_o  out  1  cnt_o >= afull_thr_i.
- aempty_o  out  1  cnt_o <= aempty_thr_i.
- clr_err_i  in  1  clears sticky error flags.
- overflow_o  out  1  sticky: push attempted while full.
- underflow_o  out  1  sticky: pop attempted while empty.

## Operation
- push_hdshk = push_i & ~full_o; pop_hdshk = pop_i & ~empty_o. A rejected request has no effect on state except error flags.
- Pointers wrap modulo BUFFER_DEPTH: at BUFFER_DEPTH-1 the next value is 0, never via natural overflow.
- Count: +1 on push-only, -1 on pop-only, unchanged on push+pop or neither.
- Full: push+pop in the same cycle means only the pop is accepted; count goes to BUFFER_DEPTH-1.
- Empty: push+pop in the same cycle means only the push is accepted; no bypass of dat_i to dat_o.
- flush_i has priority over push/pop. It zeroes pointers and count. Storage is not cleared. Sticky errors are not cleared. A pop in a flush cycle does not update dat_o in registered mode.
- FWFT=1: dat_o = storage[rd_ptr], combinational from registered state; value is don't-care when empty_o.
- FWFT=0: dat_o is a register loaded with storage[rd_ptr] on pop_hdshk and held otherwise.
- Watermarks are combinational compares of registered count against quasi-static thresholds.
  - afull_thr_i > BUFFER_DEPTH: afull_o never asserts.
  - aempty_thr_i = 0: aempty_o equals empty_o.
- Errors: overflow_o sets on push_i & full_o & ~flush_i; underflow_o sets on pop_i & empty_o & ~flush_i. clr_err_i clears; a set in the same cycle as clr_err_i wins.

## Timing
- Reset values:
  - cnt_o 0, empty_o 1, full_o 0.
  - afull_o = (afull_thr_i == 0); aempty_o 1.
  - dat_o 0 (registered mode; storage resets to 0, so FWFT dat_o also reads 0).
  - overflow_o 0, underflow_o 0.
- Reset asserted mid-operation returns all state to these values immediately (asynchronous).
- Push at edge N: cnt_o/empty_o/full_o/watermarks update after edge N. In FWFT mode, data is visible on dat_o after edge N.
- Registered-mode pop at edge N: popped word on dat_o after edge N, held until the next accepted pop.
- Error flags assert one cycle after the offending request.

## Configuration
- FIFO_WM_ERR_EN defined: sticky overflow/underflow logic and clr_err_i are implemented as above.
- Not defined: overflow_o and underflow_o tied 0; clr_err_i unused. The port list is unchanged in both cases.

## Structure
- Shared package fifo_pkg holds the FWFT/registered mode constants (FIFO_MODE_FWFT = 1, FIFO_MODE_REG = 0) and a helper function for occupancy width.
- Sub-module fifo_wrap_ptr: modulo-BUFFER_DEPTH pointer with inc and clr inputs, asynchronous reset. It is instantiated twice (read and write pointers).
- Storage is a flop array with asynchronous reset, written at wr_ptr on push_hdshk.

## Test plan
- DEPTH=6, FWFT=1: push 0x11..0x66 -> full_o=1, cnt_o=6. A 7th push is rejected and sets overflow_o. Popping 6 returns 0x11..0x66 in order across the pointer wrap.
- DEPTH=6: fill 5, then 10 cycles of simultaneous push/pop -> cnt_o stays 5 and data order is preserved through 2 wraps.
- FWFT=0: push 0xA5, pop at edge N -> dat_o=0xA5 after N and held for the following idle cycles. Pop while empty -> dat_o unchanged, underflow_o=1; clr_err_i clears it.
- afull_thr_i=4, aempty_thr_i=1: cnt 0..6..0 -> afull_o=1 exactly for cnt>=4, aempty_o=1 exactly for cnt<=1.
- Fill 3 entries, assert flush_i with push_i and pop_i -> cnt_o=0, empty_o=1, errors unchanged. The next push/pop returns the new data only.
- Assert rst_n_i low mid-burst, between clock edges -> all outputs take their reset values immediately. Build without FIFO_WM_ERR_EN -> overflow_o/underflow_o stay 0 under overflow stimulus.
